pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC path.
- Holds the architectural PC register and fetches instructions from the shared instruction/data SRAM port using a req/ack handshake.
- Presents a {Pc, Instr, InstrValid} triple to the IF/ID stage.
- Inputs: the redirect target Npc and a Redirect strobe from the branch/jump logic; Stall from the hazard unit.

Parameters:
- DATA_W, 16, instruction and address width (word-addressed)
- RESET_PC, 16'h0000, first fetch address after reset
- NOP_INSTR, 16'h0800, instruction presented while InstrValid=0

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Stall  in  1  hold the IF/ID output triple this cycle
- Redirect  in  1  discard all fetched/in-flight instructions; restart at Npc
- Npc  in  DATA_W  redirect target, sampled only when Redirect=1
- MemReq  out  1  fetch request to SRAM arbiter
- MemAddr  out  DATA_W  fetch address
- MemAck  in  1  request accepted; MemRdata valid in the same cycle
- MemRdata  in  DATA_W  fetched instruction
- Pc  out  DATA_W  address of Instr
- Instr  out  DATA_W  instruction to IF/ID
- InstrValid  out  1  Instr/Pc hold a live instruction

Behaviour:
- Reset (async, Rst=1):
  - Pc=RESET_PC, Instr=NOP_INSTR, InstrValid=0.
  - MemReq=0, MemAddr=RESET_PC.
  - Internal fetch_pc=RESET_PC, skid empty, kill=0, state BOOT.
- States:
  - BOOT: one cycle after Rst deasserts -> REQ.
  - REQ: MemReq=1, MemAddr=fetch_pc. MemReq and MemAddr stay stable until MemAck. On MemAck -> REQ, or -> FULL if the accepted data lands in the skid.
  - FULL: MemReq=0. Leaves to REQ when the skid drains or on Redirect.
- Accepted fetch (MemAck=1, kill=0, no Redirect):
  - fetch_pc <= fetch_pc+1, wrapping modulo 2^16 (0xFFFF -> 0x0000).
  - If the output is free (Stall=0 or InstrValid=0) and the skid is empty: Instr<=MemRdata, Pc<=fetch_pc, InstrValid<=1.
  - Otherwise the data goes to the single-entry skid (data+pc).
- Output advance with Stall=0:
  - Skid non-empty: the output loads from the skid. A same-cycle ack loads into the skid.
  - Skid empty and no ack: InstrValid<=0, Instr<=NOP_INSTR.
- Stall=1: Pc/Instr/InstrValid hold exactly.
- Redirect=1, which has priority over Stall and ack data:
  - InstrValid<=0, Instr<=NOP_INSTR, skid cleared, fetch_pc<=Npc.
  - If REQ is pending without ack this cycle: kill<=1. The request completes at its original address and the data is dropped on ack. kill clears and the next request uses Npc.
  - If Redirect coincides with MemAck: the data is dropped and the next cycle requests Npc.
  - FULL -> REQ.
- Throughput: with zero-wait memory (MemAck whenever MemReq), 1 instruction/cycle. First InstrValid occurs 2 cycles after Rst falls.
- Reset mid-handshake: MemReq drops immediately. A pending ack is ignored.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- Defined:
  - Adds outputs FetchCnt[15:0] (accepted, non-killed fetches) and KillCnt[15:0] (fetches dropped by kill or a coincident Redirect).
  - Both counters are saturating, cleared by Rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared cpu package:
  - DATA_W, RESET_PC, NOP_INSTR constants.
  - Fetch state encoding enum {BOOT, REQ, FULL}.
- One natural sub-module: fetch_skid_buf. A one-entry data+pc buffer with load/drain/clear, reusable by the MEM stage.

Test Plan:
- Reset then zero-wait memory returning MemRdata=addr^16'hA5A5 -> first InstrValid 2 cycles after Rst falls with Pc=0000, Instr=A5A5; then Pc 0001, 0002 on consecutive cycles.
- Stall held 3 cycles during streaming -> output frozen. One fetch is buffered in the skid, then MemReq=0 (FULL). On release the sequence continues with no gap and no duplicate.
- MemAck delayed 2 cycles; Redirect with Npc=0x0040 during the wait -> MemAddr stays at the old address until ack, that data is dropped, the next MemAddr is 0x0040, and the first valid Pc is 0x0040.
- Redirect and Stall together with the skid full -> InstrValid=0 next cycle, skid empty, fetch resumes at Npc.
- Redirect Npc=0xFFFF, zero-wait memory -> Pc sequence FFFF, 0000, 0001.
- Rst asserted while MemReq=1 and MemAck pending -> MemReq=0 and outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared fetch constants and the fetch FSM state encoding.
package pc_fetch_pkg;
  localparam int             DATA_W    = 16;
  localparam logic [15:0]    RESET_PC  = 16'h0000;
  localparam logic [15:0]    NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry data+pc holding buffer with load/drain/clear.
// Priority: clear > load > drain, so load+drain in one cycle replaces the entry.
module fetch_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] in_pc,
  output logic         valid,
  output logic [W-1:0] out_data,
  output logic [W-1:0] out_pc
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] pc_q, pc_d;

  // Next-entry selection.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      pc_d    = in_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid    = valid_q;
  assign out_data = data_q;
  assign out_pc   = pc_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// PC register + instruction fetch over a req/ack SRAM port, feeding IF/ID.
// Optional build macro PC_FETCH_PERF_EN adds saturating FetchCnt/KillCnt.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int                 DATA_W    = pc_fetch_pkg::DATA_W,
  parameter logic [DATA_W-1:0]  RESET_PC  = pc_fetch_pkg::RESET_PC,
  parameter logic [DATA_W-1:0]  NOP_INSTR = pc_fetch_pkg::NOP_INSTR
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [DATA_W-1:0] Npc,
  output logic              MemReq,
  output logic [DATA_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRdata,
  output logic [DATA_W-1:0] Pc,
  output logic [DATA_W-1:0] Instr,
  output logic              InstrValid
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [15:0]       FetchCnt,
  output logic [15:0]       KillCnt
`endif
);
  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  // Redirect target parked while a killed request is still outstanding,
  // so MemAddr keeps the original address until the ack.
  logic [DATA_W-1:0] redir_pc_q, redir_pc_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;

  logic              ack_live, take, out_free;
  logic              skid_load, skid_drain, skid_clear, skid_valid;
  logic [DATA_W-1:0] skid_data, skid_pc;

  assign ack_live = mem_req_q && MemAck;
  assign take     = ack_live && !kill_q && !Redirect;
  assign out_free = !Stall || !valid_q;

  fetch_skid_buf #(.W(DATA_W)) u_skid (
    .clk      (Clk),
    .rst      (Rst),
    .load     (skid_load),
    .drain    (skid_drain),
    .clear    (skid_clear),
    .in_data  (MemRdata),
    .in_pc    (fetch_pc_q),
    .valid    (skid_valid),
    .out_data (skid_data),
    .out_pc   (skid_pc)
  );

  // Output triple and skid steering; Redirect overrides stall and ack data.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
    if (Redirect) begin
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      skid_clear = 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        pc_d       = skid_pc;
        instr_d    = skid_data;
        valid_d    = 1'b1;
        skid_drain = 1'b1;
        skid_load  = take;
      end else if (take) begin
        pc_d    = fetch_pc_q;
        instr_d = MemRdata;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end else begin
      skid_load = take;
    end
  end

  // Fetch FSM: address sequencing, kill tracking and request generation.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    redir_pc_d = redir_pc_q;
    kill_d     = kill_q;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        if (Redirect) fetch_pc_d = Npc;
      end
      ST_REQ: begin
        if (Redirect) begin
          if (ack_live) begin
            fetch_pc_d = Npc;
            kill_d     = 1'b0;
          end else begin
            redir_pc_d = Npc;
            kill_d     = 1'b1;
          end
        end else if (ack_live) begin
          if (kill_q) begin
            fetch_pc_d = redir_pc_q;
            kill_d     = 1'b0;
          end else begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            if (skid_load) state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (Redirect) begin
          fetch_pc_d = Npc;
          state_d    = ST_REQ;
        end else if (skid_drain && !skid_load) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    mem_req_d = (state_d == ST_REQ);
  end

  // State registers; async reset drops MemReq at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_BOOT;
      mem_req_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      redir_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
      kill_q     <= kill_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign MemReq     = mem_req_q;
  assign MemAddr    = fetch_pc_q;
  assign Pc         = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;

`ifdef PC_FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] kill_cnt_q, kill_cnt_d;

  // Saturating counts of delivered vs. dropped fetches.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (take && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (ack_live && (kill_q || Redirect) && kill_cnt_q != 16'hFFFF)
      kill_cnt_d = kill_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign FetchCnt = fetch_cnt_q;
  assign KillCnt  = kill_cnt_q;
`endif
endmodule
